// File: rtl/led_pattern_ctrl.sv
// LED bar sequencer: valid/ready command port, IDLE/RUN FSM, prescaler and four step patterns.
// Build option: define LED_CTRL_COUNT_MODE_EN to implement COUNT mode; otherwise mode 11 runs as FILL.
module led_pattern_ctrl #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_mode,
    input  logic [DIV_W-1:0] cmd_div,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             tick,
    output logic             state_dbg
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is low only while rst is asserted, and the command fields are sampled at that edge.

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        M_FILL   = 2'b00,
        M_ROTATE = 2'b01,
        M_BOUNCE = 2'b10,
        M_COUNT  = 2'b11
    } mode_t;

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_STEP  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LED_TWO = LED_ONE << 1;
    localparam logic [DIV_W-1:0] PRE_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   pre_q, pre_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   led_q, led_d;
    logic               tick_q, tick_d;

    logic               accept;
    mode_t              start_mode;
    logic [WIDTH-1:0]   step_led;
    logic               step_dir;

    assign accept = cmd_valid && cmd_ready;

    // Without the COUNT option mode 11 is folded onto FILL at latch time, so no adder exists.
    always_comb begin
`ifdef LED_CTRL_COUNT_MODE_EN
        start_mode = mode_t'(cmd_mode);
`else
        start_mode = (cmd_mode == 2'b11) ? M_FILL : mode_t'(cmd_mode);
`endif
    end

    // One pattern step from the current LED value, mode and bounce direction.
    always_comb begin
        step_led = led_q;
        step_dir = dir_q;
        case (mode_q)
            M_FILL: begin
                step_led = {led_q[WIDTH-2:0], ~led_q[WIDTH-1]};
            end
            M_ROTATE: begin
                step_led = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            end
            M_BOUNCE: begin
                if (dir_q == DIR_LEFT) begin
                    if (led_q[WIDTH-1]) begin
                        step_dir = DIR_RIGHT;
                        step_led = led_q >> 1;
                    end else begin
                        step_led = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        step_dir = DIR_LEFT;
                        step_led = LED_TWO;
                    end else begin
                        step_led = led_q >> 1;
                    end
                end
            end
            M_COUNT: begin
`ifdef LED_CTRL_COUNT_MODE_EN
                step_led = led_q + LED_ONE;
`else
                step_led = {led_q[WIDTH-2:0], ~led_q[WIDTH-1]};
`endif
            end
            default: begin
                step_led = led_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = div_q;
        pre_d   = pre_q;
        dir_d   = dir_q;
        led_d   = led_q;
        tick_d  = 1'b0;

        if (accept && cmd_op == OP_START) begin
            state_d = ST_RUN;
            mode_d  = start_mode;
            div_d   = cmd_div;
            pre_d   = '0;
            // Entry fix-up replaces the step that would otherwise happen at this edge.
            if (start_mode == M_ROTATE && led_q == '0) begin
                led_d = LED_ONE;
            end else if (start_mode == M_BOUNCE && !$onehot(led_q)) begin
                led_d = LED_ONE;
                dir_d = DIR_LEFT;
            end
        end else if (accept && cmd_op == OP_STOP) begin
            state_d = ST_IDLE;
            pre_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (pre_q == div_q) begin
                pre_d  = '0;
                led_d  = step_led;
                dir_d  = step_dir;
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end else if (accept && cmd_op == OP_STEP) begin
            led_d  = step_led;
            dir_d  = step_dir;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= M_FILL;
            div_q   <= '0;
            pre_q   <= '0;
            dir_q   <= DIR_LEFT;
            led_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            pre_q   <= pre_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
        end
    end

    assign cmd_ready = rst;
    assign led       = led_q;
    assign busy      = (state_q == ST_RUN);
    assign tick      = tick_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: scoreboard of expected LED steps plus immediate-assert checks.
module tb_led_pattern_ctrl;
  localparam int W  = 16;
  localparam int DW = 24;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_STEP  = 2'b11;
  localparam logic [1:0] MD_FILL   = 2'b00;
  localparam logic [1:0] MD_ROTATE = 2'b01;
  localparam logic [1:0] MD_BOUNCE = 2'b10;
  localparam logic [1:0] MD_COUNT  = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = OP_NOP;
  logic [1:0]    cmd_mode = MD_FILL;
  logic [DW-1:0] cmd_div = '0;
  logic [W-1:0]  led;
  logic          busy;
  logic          tick;
  logic          state_dbg;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;

  led_pattern_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mode  (cmd_mode),
    .cmd_div   (cmd_div),
    .led       (led),
    .busy      (busy),
    .tick      (tick),
    .state_dbg (state_dbg)
  );

  // clock: posedges at 5, 15, ...; the bench drives and samples on negedges
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] mode, input logic [DW-1:0] div);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mode  = mode;
    cmd_div   = div;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic expect_step(input int gap_exp, input string tag);
    int gap;
    logic [W-1:0] e;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (tick !== 1'b1 && gap < gap_exp + 2);
    chk({tag, "_gap"}, gap, gap_exp);
    e = exp_q.pop_front();
    chk({tag, "_led"}, led, e);
  endtask

  task automatic step_idle(input string tag);
    logic [W-1:0] e;
    send(OP_STEP, MD_FILL, '0);
    e = exp_q.pop_front();
    chk({tag, "_led"}, led, e);
    chk({tag, "_tick"}, tick, 1'b1);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ready", cmd_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_rst", cmd_ready, 1);
    @(negedge clk);

    // FILL div=0: full 32-step period and back to 0001
    for (int i = 1; i <= 16; i++) exp_q.push_back(W'((32'd1 << i) - 1));
    for (int i = 1; i <= 16; i++) exp_q.push_back(W'(32'hFFFF << i));
    exp_q.push_back(16'h0001);
    send(OP_START, MD_FILL, 24'd0);
    chk("fill_busy", busy, 1);
    chk("fill_entry_led", led, 0);
    chk("fill_entry_tick", tick, 0);
    for (int i = 0; i < 33; i++) expect_step(1, "fill");
    send(OP_STOP, MD_FILL, 24'd0);
    chk("stop_busy", busy, 0);
    chk("stop_led", led, 16'h0001);
    chk("stop_tick", tick, 0);

    // asynchronous reset in the middle of a run
    send(OP_START, MD_FILL, 24'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b1;

    // ROTATE div=3 from led=0
    for (int i = 1; i < 16; i++) exp_q.push_back(W'(32'd1 << i));
    exp_q.push_back(16'h0001);
    send(OP_START, MD_ROTATE, 24'd3);
    chk("rot_entry_led", led, 16'h0001);
    chk("rot_busy", busy, 1);
    for (int i = 0; i < 16; i++) expect_step(4, "rot");
    send(OP_STOP, MD_FILL, 24'd0);
    chk("rot_stop_led", led, 16'h0001);

    // build 0006 with idle steps: FILL 1->3, then ROTATE 3->6
    send(OP_START, MD_FILL, 24'd100);
    send(OP_STOP, MD_FILL, 24'd0);
    exp_q.push_back(16'h0003);
    step_idle("prep_fill");
    send(OP_START, MD_ROTATE, 24'd100);
    send(OP_STOP, MD_FILL, 24'd0);
    exp_q.push_back(16'h0006);
    step_idle("prep_rot");

    // BOUNCE div=0 from a non-one-hot value
    for (int i = 1; i < 16; i++) exp_q.push_back(W'(32'd1 << i));
    for (int i = 14; i >= 0; i--) exp_q.push_back(W'(32'd1 << i));
    exp_q.push_back(16'h0002);
    send(OP_START, MD_BOUNCE, 24'd0);
    chk("bounce_entry_led", led, 16'h0001);
    for (int i = 0; i < 31; i++) expect_step(1, "bounce");
    send(OP_STOP, MD_FILL, 24'd0);

    // FILL div=1, STOP freezes, then idle STEPs and an ignored STEP in RUN
    pulse_reset();
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0007);
    send(OP_START, MD_FILL, 24'd1);
    for (int i = 0; i < 3; i++) expect_step(2, "fill1");
    send(OP_STOP, MD_FILL, 24'd0);
    chk("fill1_stop_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("fill1_frozen", led, 16'h0007);
    exp_q.push_back(16'h000F);
    exp_q.push_back(16'h001F);
    exp_q.push_back(16'h003F);
    for (int i = 0; i < 3; i++) step_idle("idle_step");
    @(negedge clk);
    chk("tick_one_cycle", tick, 0);
    send(OP_START, MD_FILL, 24'd50);
    send(OP_STEP, MD_FILL, 24'd0);
    chk("run_step_led", led, 16'h003F);
    chk("run_step_tick", tick, 0);
    chk("run_step_busy", busy, 1);
    send(OP_STOP, MD_FILL, 24'd0);

    // START while running restarts the prescaler with the new divider
    pulse_reset();
    exp_q.push_back(16'h0001);
    send(OP_START, MD_FILL, 24'd2);
    send(OP_START, MD_FILL, 24'd4);
    expect_step(5, "restart");
    send(OP_STOP, MD_FILL, 24'd0);

    // reach FFFF, STOP on a step edge (suppressed), then COUNT step
    pulse_reset();
    for (int i = 1; i <= 16; i++) exp_q.push_back(W'((32'd1 << i) - 1));
    send(OP_START, MD_FILL, 24'd0);
    for (int i = 0; i < 16; i++) expect_step(1, "to_ffff");
    send(OP_STOP, MD_FILL, 24'd0);
    chk("stop_suppress_led", led, 16'hFFFF);
    chk("stop_suppress_tick", tick, 0);
    send(OP_START, MD_COUNT, 24'd100);
    chk("count_entry_led", led, 16'hFFFF);
    send(OP_STOP, MD_FILL, 24'd0);
`ifdef LED_CTRL_COUNT_MODE_EN
    exp_q.push_back(16'h0000);
`else
    exp_q.push_back(16'hFFFE);
`endif
    step_idle("count");

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
